// File: rtl/eig_pkg.sv
// eig_pkg: shared types and constants for the eigenvalue-core scheduler.
//   sched_state_t : scheduler FSM state encoding
//   REG_*         : one-hot regime codes returned by the core
//   EIG_*_DEF     : default parameter values
//   eig_id_w()    : requester-index width, never narrower than one bit
package eig_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StIssue,
        StWait,
        StResp
    } sched_state_t;

    localparam logic [2:0] REG_OVER  = 3'b100;
    localparam logic [2:0] REG_CRIT  = 3'b010;
    localparam logic [2:0] REG_UNDER = 3'b001;

    localparam int unsigned EIG_NREQ_DEF = 4;
    localparam int unsigned EIG_W_DEF    = 32;
    localparam int unsigned EIG_TMO_DEF  = 1024;

    // A single requester still gets a 1-bit id so ports never collapse to zero width.
    function automatic int unsigned eig_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eig_rr_arb.sv
// eig_rr_arb: combinational round-robin picker.
// Returns the first set bit of valid at or after ptr, scanning upward and wrapping.
//   valid  in  N    request vector
//   ptr    in  IdW  starting index of the scan
//   any    out 1    at least one request present
//   gnt_id out IdW  index of the chosen request (0 when any is low)
module eig_rr_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = 2
) (
    input  logic [N-1:0]   valid,
    input  logic [IdW-1:0] ptr,
    output logic           any,
    output logic [IdW-1:0] gnt_id
);

    logic [IdW-1:0] idx;
    logic           found;

    assign any = |valid;

    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && valid[idx]) begin
                gnt_id = idx;
                found  = 1'b1;
            end
            // Wrap explicitly so non-power-of-two N never walks past the top requester.
            idx = (idx == IdW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/eig_sched.sv
// eig_sched: round-robin scheduler sharing one eigenvalue core among NREQ requesters.
// One transaction in flight: grant, accept operands, start core, wait for done,
// return the result tagged with the requester id, then rotate priority.
// Optional macro EIG_SCHED_TMO_EN adds a completion timeout (TMO cycles) and a
// saturating 8-bit err_count output; without it rsp_err is 0 and WAIT is unbounded.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-requester handshake (ready one-hot or zero)
//   req_a0/req_a1                  packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/kappa/inv_kappa/regime  captured result, rsp_err flags a timeout
//   core_ena/core_start            core enable and single-cycle start
//   core_a0/core_a1                registered operands to the core
//   core_done/kappa/inv/regime     core completion pulse and results
//   err_count                      (EIG_SCHED_TMO_EN only) timeout count
module eig_sched
    import eig_pkg::*;
#(
    parameter int unsigned NREQ = EIG_NREQ_DEF,
    parameter int unsigned W    = EIG_W_DEF,
    parameter int unsigned TMO  = EIG_TMO_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*W-1:0]           req_a0,
    input  logic [NREQ*W-1:0]           req_a1,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [eig_id_w(NREQ)-1:0]   rsp_id,
    output logic [W-1:0]                rsp_kappa,
    output logic [W-1:0]                rsp_inv_kappa,
    output logic [2:0]                  rsp_regime,
    output logic                        rsp_err,
    output logic                        core_ena,
    output logic                        core_start,
    output logic [W-1:0]                core_a0,
    output logic [W-1:0]                core_a1,
    input  logic                        core_done,
    input  logic [W-1:0]                core_kappa,
    input  logic [W-1:0]                core_inv_kappa,
    input  logic [2:0]                  core_regime
`ifdef EIG_SCHED_TMO_EN
    ,
    output logic [7:0]                  err_count
`endif
);

    localparam int unsigned IdW = eig_id_w(NREQ);

    if (NREQ < 1 || NREQ > 8 || W < 2 || TMO < 2) begin : g_bad_param
        $error("eig_sched: parameter out of range");
    end

    sched_state_t   state_q, state_d;
    logic [IdW-1:0] gnt_q, gnt_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   a0_q, a0_d, a1_q, a1_d;
    logic [W-1:0]   kappa_q, kappa_d, inv_q, inv_d;
    logic [2:0]     regime_q, regime_d;

    logic           arb_any;
    logic [IdW-1:0] arb_gnt;

`ifdef EIG_SCHED_TMO_EN
    localparam int unsigned CntW = $clog2(TMO);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
`endif

    eig_rr_arb #(
        .N   (NREQ),
        .IdW (IdW)
    ) u_arb (
        .valid  (req_valid),
        .ptr    (rr_ptr_q),
        .any    (arb_any),
        .gnt_id (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            a0_q     <= '0;
            a1_q     <= '0;
            kappa_q  <= '0;
            inv_q    <= '0;
            regime_q <= '0;
`ifdef EIG_SCHED_TMO_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            a0_q     <= a0_d;
            a1_q     <= a1_d;
            kappa_q  <= kappa_d;
            inv_q    <= inv_d;
            regime_q <= regime_d;
`ifdef EIG_SCHED_TMO_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        a0_d       = a0_q;
        a1_d       = a1_q;
        kappa_d    = kappa_q;
        inv_d      = inv_q;
        regime_d   = regime_q;
        req_ready  = '0;
        core_ena   = 1'b0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
`ifdef EIG_SCHED_TMO_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                req_ready[gnt_q] = 1'b1;
                if (req_valid[gnt_q]) begin
                    a0_d    = req_a0[gnt_q*W +: W];
                    a1_d    = req_a1[gnt_q*W +: W];
                    state_d = StIssue;
                end else begin
                    // Requester withdrew: abandon without touching the priority pointer.
                    state_d = StIdle;
                end
            end
            StIssue: begin
                core_ena   = 1'b1;
                core_start = 1'b1;
                state_d    = StWait;
`ifdef EIG_SCHED_TMO_EN
                cnt_d = '0;
`endif
            end
            StWait: begin
                core_ena = 1'b1;
                if (core_done) begin
                    kappa_d  = core_kappa;
                    inv_d    = core_inv_kappa;
                    regime_d = core_regime;
                    state_d  = StResp;
`ifdef EIG_SCHED_TMO_EN
                    err_d = 1'b0;
                end else if (cnt_q == CntW'(TMO - 1)) begin
                    // Leaving WAIT drops core_ena for the RESP cycle, resetting the core.
                    kappa_d  = '0;
                    inv_d    = '0;
                    regime_d = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                    if (err_cnt_q != 8'hff) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_ptr_d = (gnt_q == IdW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rsp_id        = gnt_q;
    assign rsp_kappa     = kappa_q;
    assign rsp_inv_kappa = inv_q;
    assign rsp_regime    = regime_q;
    assign core_a0       = a0_q;
    assign core_a1       = a1_q;

`ifdef EIG_SCHED_TMO_EN
    assign rsp_err   = err_q;
    assign err_count = err_cnt_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_eig_sched.sv
// tb_eig_sched: randomized self-checking bench for eig_sched (NREQ=4, W=32, TMO=64).
// A transaction-level model tracks the round-robin pointer and expected results;
// a small core model answers core_start with a done pulse after a chosen latency.
module tb_eig_sched;
    import eig_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned TMO  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a0;
    logic [NREQ*W-1:0] req_a1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_kappa;
    logic [W-1:0]      rsp_inv_kappa;
    logic [2:0]        rsp_regime;
    logic              rsp_err;
    logic              core_ena;
    logic              core_start;
    logic [W-1:0]      core_a0;
    logic [W-1:0]      core_a1;
    logic              core_done;
    logic [W-1:0]      core_kappa;
    logic [W-1:0]      core_inv_kappa;
    logic [2:0]        core_regime;
`ifdef EIG_SCHED_TMO_EN
    logic [7:0]        err_count;
`endif

    eig_sched #(
        .NREQ (NREQ),
        .W    (W),
        .TMO  (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a0         (req_a0),
        .req_a1         (req_a1),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_kappa      (rsp_kappa),
        .rsp_inv_kappa  (rsp_inv_kappa),
        .rsp_regime     (rsp_regime),
        .rsp_err        (rsp_err),
        .core_ena       (core_ena),
        .core_start     (core_start),
        .core_a0        (core_a0),
        .core_a1        (core_a1),
        .core_done      (core_done),
        .core_kappa     (core_kappa),
        .core_inv_kappa (core_inv_kappa),
        .core_regime    (core_regime)
`ifdef EIG_SCHED_TMO_EN
        ,
        .err_count      (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int           rr = 0;
    logic [W-1:0] a0_v [NREQ];
    logic [W-1:0] a1_v [NREQ];

    // Core model controls and state.
    logic [W-1:0] mk, mik;
    logic [2:0]   mrg;
    int           core_lat  = 4;
    bit           core_hang = 1'b0;
    bit           core_busy = 1'b0;
    int           core_cnt  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2:0] rand_regime();
        case ($urandom_range(0, 2))
            0:       return REG_OVER;
            1:       return REG_CRIT;
            default: return REG_UNDER;
        endcase
    endfunction

    task automatic set_data(input int i, input logic [W-1:0] a0, input logic [W-1:0] a1);
        a0_v[i] = a0;
        a1_v[i] = a1;
        req_a0[i*W +: W] = a0;
        req_a1[i*W +: W] = a1;
    endtask

    task automatic set_data_rand();
        for (int i = 0; i < NREQ; i++) set_data(i, $urandom, $urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, 64'({req_ready, core_ena, core_start, rsp_valid, rsp_err}), 64'd0);
        check_val({tag, "_res"}, {rsp_kappa, rsp_inv_kappa}, 64'd0);
        check_val({tag, "_id"}, 64'({rsp_regime, rsp_id}), 64'd0);
        check_val({tag, "_ops"}, {core_a0, core_a1}, 64'd0);
    endtask

    // Core model: done pulse core_lat cycles after the start cycle; rst does not stop it.
    initial begin
        core_done      = 1'b0;
        core_kappa     = '0;
        core_inv_kappa = '0;
        core_regime    = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (core_start) begin
                core_busy = 1'b1;
                core_cnt  = core_lat;
            end else if (core_busy && !core_hang) begin
                core_cnt--;
                if (core_cnt <= 0) begin
                    core_done      = 1'b1;
                    core_kappa     = mk;
                    core_inv_kappa = mik;
                    core_regime    = mrg;
                    core_busy      = 1'b0;
                end
            end
        end
    end

    // One full transaction, starting with the DUT idle and ending one cycle after the handshake.
    task automatic do_txn(input logic [NREQ-1:0] vmask, input int lat, input int stall,
                          input logic [W-1:0] k, input logic [W-1:0] ik, input logic [2:0] rg);
        int   g;
        int   n;
        logic bad;
        g         = pick(vmask, rr);
        mk        = k;
        mik       = ik;
        mrg       = rg;
        core_lat  = lat;
        rsp_ready = (stall == 0);
        req_valid = vmask;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check_val("gnt_lat", 64'(n), 64'd1);
        check_val("grant", 64'(req_ready), 64'(1) << g);
        tick();
        check_val("issue", 64'({core_start, core_ena, |req_ready}), 64'b110);
        check_val("core_a0", 64'(core_a0), 64'(a0_v[g]));
        check_val("core_a1", 64'(core_a1), 64'(a1_v[g]));
        bad = 1'b0;
        n   = 0;
        tick();
        while (!core_done && n < 200) begin
            if (!core_ena || core_start || rsp_valid || req_ready != '0) bad = 1'b1;
            tick();
            n++;
        end
        if (!core_ena || core_start || rsp_valid || req_ready != '0) bad = 1'b1;
        check_val("wait_busy", 64'(bad), 64'd0);
        check_val("done_seen", 64'(core_done), 64'd1);
        tick();
        check_val("rsp_valid", 64'(rsp_valid), 64'd1);
        check_val("rsp_id", 64'(rsp_id), 64'(g));
        check_val("rsp_res", {rsp_kappa, rsp_inv_kappa}, {k, ik});
        check_val("rsp_flags", 64'({rsp_regime, rsp_err, core_ena}), 64'({rg, 1'b0, 1'b0}));
        bad = 1'b0;
        for (int s = 1; s < stall; s++) begin
            tick();
            if (!rsp_valid || rsp_id != 2'(g) || rsp_kappa != k || rsp_inv_kappa != ik ||
                rsp_regime != rg || req_ready != '0) bad = 1'b1;
        end
        if (stall > 0) check_val("stall_hold", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        tick();
        check_val("rsp_drop", 64'(rsp_valid), 64'd0);
        rr = (g + 1) % NREQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int   g;
        int   n;
        logic bad;
        rst       = 1'b1;
        req_valid = '0;
        req_a0    = '0;
        req_a1    = '0;
        rsp_ready = 1'b0;
        mk = '0; mik = '0; mrg = '0;
        for (int i = 0; i < NREQ; i++) set_data(i, '0, '0);
        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        rr  = 0;

        // Single request from requester 0 with known values.
        set_data_rand();
        set_data(0, 32'd100, 32'd10);
        do_txn(4'b0001, 20, 0, 32'd5, 32'd13107, REG_UNDER);

        // Fairness after a fresh reset: all requesters held, expect 0,1,2,3,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr  = 0;
        for (int i = 0; i < 6; i++) begin
            set_data_rand();
            do_txn(4'b1111, $urandom_range(1, 6), 0, $urandom, $urandom, rand_regime());
        end

        // Backpressure; the following transaction checks the grant latency after the handshake.
        set_data_rand();
        do_txn(4'b1111, 5, 10, $urandom, $urandom, rand_regime());
        set_data_rand();
        do_txn(4'b1111, 3, 0, $urandom, $urandom, rand_regime());

        // Withdraw requester 2 during its grant cycle.
        req_valid = 4'b0100;
        tick();
        check_val("wd_grant", 64'(req_ready), 64'b0100);
        req_valid = '0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_start || core_ena || rsp_valid || req_ready != '0) bad = 1'b1;
        end
        check_val("wd_quiet", 64'(bad), 64'd0);
        set_data_rand();
        do_txn(4'b1111, 2, 0, $urandom, $urandom, rand_regime());

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            set_data_rand();
            do_txn(m, $urandom_range(1, 8), $urandom_range(0, 3), $urandom, $urandom,
                   rand_regime());
        end

        // Reset while the core is busy; its late done must be ignored.
        set_data_rand();
        core_lat  = 20;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        tick();
        check_val("rw_grant", 64'(req_ready), 64'(1) << pick(4'b0010, rr));
        tick();
        req_valid = '0;
        check_val("rw_start", 64'(core_start), 64'd1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr  = 0;
        check_all_zero("rst_wait");
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid || core_ena || core_start || req_ready != '0) bad = 1'b1;
        end
        check_val("stray_done", 64'(bad), 64'd0);
        set_data_rand();
        do_txn(4'b1111, 4, 1, $urandom, $urandom, rand_regime());

`ifdef EIG_SCHED_TMO_EN
        // Core never answers: response after TMO cycles of WAIT with error set.
        set_data_rand();
        core_hang = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        g = pick(4'b0001, rr);
        tick();
        check_val("tmo_grant", 64'(req_ready), 64'(1) << g);
        tick();
        check_val("tmo_start", 64'(core_start), 64'd1);
        n = 0;
        while (!rsp_valid && n < 300) begin
            tick();
            n++;
        end
        check_val("tmo_lat", 64'(n), 64'(TMO + 1));
        check_val("tmo_err", 64'({rsp_err, core_ena}), 64'b10);
        check_val("tmo_res", {rsp_kappa, rsp_inv_kappa}, 64'd0);
        check_val("tmo_regime", 64'(rsp_regime), 64'd0);
        check_val("tmo_cnt", 64'(err_count), 64'd1);
        tick();
        rr        = (g + 1) % NREQ;
        core_hang = 1'b0;
        set_data_rand();
        do_txn(4'b1111, 5, 0, $urandom, $urandom, rand_regime());
        check_val("tmo_cnt_hold", 64'(err_count), 64'd1);
`endif

        req_valid = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
